// File: rtl/bcd_digit_entry.sv
// Debounced BCD keypad entry: stable digits shift into an N-digit packed BCD
// register (newest digit in nibble 0), with clear/backspace editing and status.
module bcd_digit_entry #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int CW           = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              digit_in,
  input  logic                    digit_valid,
  input  logic                    clear,
  input  logic                    backspace,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [CW-1:0]           digit_count,
  output logic                    full,
  output logic                    accept,
  output logic                    reject,
  output logic                    err
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  state_t          state;
  logic [3:0]      candidate;
  logic [SW-1:0]   stab_cnt;
  logic            legal;
  logic            illegal;
  logic            commit_req;
  logic [4*NUM_DIGITS-1:0] push_val;
  logic [4*NUM_DIGITS-1:0] pop_val;

  always_comb begin
    legal      = (digit_in <= 4'd9);
    illegal    = digit_valid & ~legal;
    commit_req = 1'b0;
    if (digit_valid && legal) begin
      unique case (state)
        IDLE:     commit_req = (STABLE_CYCLES == 1);
        DEBOUNCE: commit_req = (digit_in == candidate) &&
                               (stab_cnt == SW'(STABLE_CYCLES - 1));
        default:  commit_req = 1'b0;
      endcase
    end
  end

  // digit_in equals the candidate whenever a commit is requested, and it is
  // the only valid source when STABLE_CYCLES==1 commits straight from IDLE.
  generate
    if (NUM_DIGITS == 1) begin : g_single
      assign push_val = digit_in;
      assign pop_val  = '0;
    end else begin : g_multi
      assign push_val = {bcd_out[4*NUM_DIGITS-5:0], digit_in};
      assign pop_val  = {4'h0, bcd_out[4*NUM_DIGITS-1:4]};
    end
  endgenerate

  assign full = (digit_count == CW'(NUM_DIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      candidate <= '0;
      stab_cnt  <= '0;
    end else if (illegal) begin
      state    <= IDLE;
      stab_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (digit_valid) begin
            candidate <= digit_in;
            stab_cnt  <= SW'(1);
            state     <= (STABLE_CYCLES == 1) ? HELD : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!digit_valid) begin
            state    <= IDLE;
            stab_cnt <= '0;
          end else if (digit_in != candidate) begin
            candidate <= digit_in;
            stab_cnt  <= SW'(1);
          end else if (commit_req) begin
            state    <= HELD;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
        HELD: begin
          if (!digit_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out     <= '0;
      digit_count <= '0;
      accept      <= 1'b0;
      reject      <= 1'b0;
      err         <= 1'b0;
    end else begin
      accept <= 1'b0;
      reject <= 1'b0;
      if (clear) begin
        bcd_out     <= '0;
        digit_count <= '0;
        err         <= 1'b0;
        reject      <= commit_req;
      end else begin
        if (illegal) err <= 1'b1;
        // Any backspace strobe outranks a same-cycle commit, even on an empty entry.
        if (backspace) begin
          if (digit_count != '0) begin
            bcd_out     <= pop_val;
            digit_count <= digit_count - CW'(1);
          end
          reject <= commit_req;
        end else if (commit_req) begin
          if (full) begin
            reject <= 1'b1;
          end else begin
            bcd_out     <= push_val;
            digit_count <= digit_count + CW'(1);
            accept      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/bcd_digit_entry.md
Name: bcd_digit_entry

Overview:
Consumes the 4-bit BCD digit and valid flag from the keypad one-hot-to-BCD encoder. Each valid digit is debounced, then shifted into an N-digit packed BCD entry register, most-recent digit in the least-significant nibble. Provides clear and backspace editing plus full, accept, reject and error status. The entry register feeds downstream display and compare logic.

Parameters:
NUM_DIGITS, 4, number of BCD digits held (>=1); bcd_out width = 4*NUM_DIGITS
STABLE_CYCLES, 4, consecutive clock samples of an unchanged valid digit required before commit (>=1)
CW, $clog2(NUM_DIGITS+1), derived width of digit_count (localparam)

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
digit_in  input  4  BCD digit from encoder (0-9 legal)
digit_valid  input  1  encoder valid; high while exactly one key is pressed
clear  input  1  synchronous clear of entry register and error flag
backspace  input  1  synchronous single-cycle strobe; delete most recent digit
bcd_out  output  4*NUM_DIGITS  packed BCD entry; nibble 0 = newest digit
digit_count  output  CW  number of digits entered, 0..NUM_DIGITS
full  output  1  digit_count == NUM_DIGITS (combinational from count)
accept  output  1  one-cycle pulse: digit committed this cycle
reject  output  1  one-cycle pulse: debounced digit discarded (full or overridden)
err  output  1  sticky: digit_valid seen with digit_in > 9

Behaviour:
- Reset (async, rst=1): bcd_out=0, digit_count=0, accept=0, reject=0, err=0, FSM=IDLE, stability counter=0, candidate=0.
- FSM states: IDLE, DEBOUNCE, HELD. The FSM ignores clear and backspace.
- IDLE: digit_valid=1 and digit_in<=9: latch candidate=digit_in, counter=1, go to DEBOUNCE. STABLE_CYCLES=1: commit on this same edge and go to HELD.
- DEBOUNCE: digit_valid=0 goes to IDLE. digit_in != candidate (legal) reloads candidate, sets counter=1 and stays in DEBOUNCE. Otherwise the counter increments. Reaching STABLE_CYCLES triggers a commit request and a move to HELD.
- HELD: stay until digit_valid=0, then go to IDLE. No second commit for a held key.
- Illegal digit (digit_valid=1, digit_in>9) in any state: err<=1, FSM goes to IDLE, no commit. err clears only on clear or rst.
- Commit timing: the Nth consecutive matching sample is taken at edge k. bcd_out and digit_count update at edge k. accept is registered and is high in the cycle following edge k.
- Commit with digit_count<NUM_DIGITS: bcd_out <= {bcd_out[4*NUM_DIGITS-5:0], candidate}, count+1, accept=1.
- Commit with full=1: bcd_out unchanged, reject=1, FSM still goes to HELD.
- Backspace: bcd_out <= {4'h0, bcd_out[4*NUM_DIGITS-1:4]}, count-1. Ignored when count=0.
- Priority within one cycle: clear > backspace > commit.
  - clear zeroes bcd_out, digit_count and err.
  - A commit lost to clear or backspace asserts reject instead of accept.
- accept and reject are never high together. Both are 0 in every cycle without a commit request.
- rst asserted mid-debounce aborts immediately. After release, a still-held key is treated as a fresh press starting from IDLE.

Test Plan:
- Reset then press 3 (digit_in=3, valid=1) for 6 cycles and release: accept pulses once, 4 cycles after valid rises. bcd_out=16'h0003, count=1.
- Keys 1,2,3,4 each held 5 cycles with 2 idle cycles between, then key 5: bcd_out=16'h1234, full=1, and key 5 gives reject=1 with bcd_out unchanged.
- Bounce: digit 7 for 2 cycles, 0 for 1 cycle, 7 for 4 cycles: exactly one accept. Digit 7 for 2 cycles then 8 for 4 cycles: commits 8 only.
- From bcd_out=16'h0123 (count 3), pulse backspace: 16'h0012, count 2. Two more backspaces give 0, count 0. A fourth backspace changes nothing.
- digit_in=4'hC with valid=1: err=1 and no accept. Then clear: err=0, bcd_out=0. A following legal key 9 commits normally.
- clear and a commit request on the same cycle: bcd_out=0, count=0, reject=1, accept=0. Assert rst mid-DEBOUNCE: all outputs 0 asynchronously, without waiting for a clock edge.
